// File: rtl/segment_display_scheduler.sv
// Round-robin six-digit display scheduler with a bit-serial double-dabble BCD converter.
// Optional leading-zero blanking: define SEGMENT_SCHED_BLANK_EN.
module segment_display_scheduler #(
  parameter int NUM_SOURCES  = 4,
  parameter int VALUE_W      = 20,
  parameter int DIGIT_COUNT  = 6,
  parameter int DWELL_CYCLES = 50_000_000,
  localparam int IDX_W       = $clog2(NUM_SOURCES)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_SOURCES-1:0]               sourceValid,
  input  logic [NUM_SOURCES-1:0][VALUE_W-1:0]  sourceValue,
  input  logic                                 holdSelect,
  output logic [DIGIT_COUNT-1:0][3:0]          digits,
  output logic                                 digitsValid,
  output logic [IDX_W-1:0]                     activeSource,
  output logic                                 overflow
);

  localparam int BCD_DIGITS = (VALUE_W * 3 + 9) / 10 + 1;
  localparam int CNT_W      = $clog2(VALUE_W + 1);
  localparam int DWELL_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES + 1) : 1;

  typedef enum logic [1:0] {SELECT, CAPTURE, CONVERT, DISPLAY} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            pending;
  logic [IDX_W-1:0]            search_base;
  logic [VALUE_W-1:0]          shreg;
  logic [BCD_DIGITS*4-1:0]     acc;
  logic [CNT_W-1:0]            bit_cnt;
  logic [DWELL_W-1:0]          dwell_cnt;

  logic                        found;
  logic [IDX_W-1:0]            found_idx;
  logic [BCD_DIGITS*4-1:0]     acc_adj;
  logic [BCD_DIGITS*4-1:0]     acc_next;
  logic                        ovf_next;
  logic                        higher_nz;
  logic [DIGIT_COUNT-1:0][3:0] disp_next;

  // search_base is the last shown source; scanning starts one past it and ends on it
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      int cand;
      cand = (int'(search_base) + k) % NUM_SOURCES;
      if (!found && sourceValid[cand]) begin
        found     = 1'b1;
        found_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    acc_next = {acc_adj[BCD_DIGITS*4-2:0], shreg[VALUE_W-1]};

    ovf_next = 1'b0;
    for (int i = DIGIT_COUNT; i < BCD_DIGITS; i++) begin
      ovf_next = ovf_next | (|acc_next[i*4 +: 4]);
    end

    for (int i = 0; i < DIGIT_COUNT; i++) begin
      disp_next[i] = acc_next[i*4 +: 4];
    end

    higher_nz = ovf_next;
`ifdef SEGMENT_SCHED_BLANK_EN
    // A digit is blanked only when it and every digit above it are zero; digit 0 never blanks
    for (int i = DIGIT_COUNT - 1; i >= 1; i--) begin
      higher_nz = higher_nz | (|acc_next[i*4 +: 4]);
      if (!higher_nz) disp_next[i] = 4'hF;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SELECT;
      pending      <= '0;
      search_base  <= IDX_W'(NUM_SOURCES - 1);
      shreg        <= '0;
      acc          <= '0;
      bit_cnt      <= '0;
      dwell_cnt    <= '0;
      digits       <= '0;
      digitsValid  <= 1'b0;
      activeSource <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        SELECT: begin
          if (holdSelect && sourceValid[search_base]) begin
            pending <= search_base;
            state   <= CAPTURE;
          end else if (found) begin
            pending <= found_idx;
            state   <= CAPTURE;
          end else begin
            digitsValid <= 1'b0;
          end
        end
        CAPTURE: begin
          shreg   <= sourceValue[pending];
          acc     <= '0;
          bit_cnt <= CNT_W'(VALUE_W);
          state   <= CONVERT;
        end
        CONVERT: begin
          acc     <= acc_next;
          shreg   <= {shreg[VALUE_W-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
          // Final shift: all display outputs change together on this edge
          if (bit_cnt == CNT_W'(1)) begin
            digits       <= disp_next;
            overflow     <= ovf_next;
            activeSource <= pending;
            search_base  <= pending;
            digitsValid  <= 1'b1;
            dwell_cnt    <= '0;
            state        <= DISPLAY;
          end
        end
        DISPLAY: begin
          if (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1)) begin
            dwell_cnt <= '0;
            state     <= SELECT;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule
